// File: rtl/regs_wr_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regs_wr_arb_pkg;
  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_LIM_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0] RegAddrBus;
  typedef logic [DATA_W_DEF-1:0] RegBus;

  localparam RegBus ZeroWord    = '0;
  localparam logic  WriteEnable = 1'b1;
  localparam logic  RstEnable   = 1'b1;

  typedef enum logic [1:0] {GNT_NONE, GNT_EX, GNT_BUF, GNT_JTAG} gnt_e;
endpackage

// File: rtl/regs_wr_arb_buf.sv
// One-entry divider result buffer with WAW kill and starvation counter.
module regs_wr_arb_buf
  import regs_wr_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  output logic              buf_v,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_data,
  output logic              stall
);
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [3:0] cnt;
  logic       kill;

  // ex overwriting the same register makes the buffered result stale
  assign kill  = ex_we & buf_v & (ex_waddr == buf_addr);
  assign stall = buf_v & (cnt == LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      buf_v    <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      cnt      <= '0;
    end else if (grant || kill) begin
      buf_v <= 1'b0;
      cnt   <= '0;
    end else if (in_valid && !buf_v) begin
      buf_v    <= 1'b1;
      buf_addr <= in_addr;
      buf_data <= in_data;
    end else if (buf_v && ex_we && cnt != LIM) begin
      cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/regs_wr_arb.sv
// Register-file write-port arbiter: ex > {div buffer, jtag}; jtag path and
// round-robin exist only when REGS_WR_ARB_JTAG_EN is defined.
module regs_wr_arb
  import regs_wr_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              div_valid_i,
  input  logic [ADDR_W-1:0] div_waddr_i,
  input  logic [DATA_W-1:0] div_wdata_i,
  output logic              div_ready_o,
  input  logic              jtag_valid_i,
  input  logic [ADDR_W-1:0] jtag_waddr_i,
  input  logic [DATA_W-1:0] jtag_wdata_i,
  output logic              jtag_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_o,
  output logic              pend_o
);
  gnt_e              gnt;
  logic              buf_v, stall, wr;
  logic [ADDR_W-1:0] buf_addr, sel_addr;
  logic [DATA_W-1:0] buf_data, sel_data;

  regs_wr_arb_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (div_valid_i),
    .in_addr  (div_waddr_i),
    .in_data  (div_wdata_i),
    .grant    (gnt == GNT_BUF),
    .ex_we    (ex_we_i),
    .ex_waddr (ex_waddr_i),
    .buf_v    (buf_v),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .stall    (stall)
  );

`ifdef REGS_WR_ARB_JTAG_EN
  logic rr;  // 0: div preferred, 1: jtag preferred

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable)     rr <= 1'b0;
    else if (gnt == GNT_BUF)  rr <= 1'b1;
    else if (gnt == GNT_JTAG) rr <= 1'b0;
  end

  always_comb begin
    gnt = GNT_NONE;
    if (ex_we_i)                     gnt = GNT_EX;
    else if (buf_v && jtag_valid_i)  gnt = rr ? GNT_JTAG : GNT_BUF;
    else if (buf_v)                  gnt = GNT_BUF;
    else if (jtag_valid_i)           gnt = GNT_JTAG;
  end

  assign jtag_ready_o = (gnt == GNT_JTAG) & ~rst;
`else
  logic unused_jtag;
  assign unused_jtag = ^{jtag_valid_i, jtag_waddr_i, jtag_wdata_i};

  always_comb begin
    gnt = GNT_NONE;
    if (ex_we_i)    gnt = GNT_EX;
    else if (buf_v) gnt = GNT_BUF;
  end

  assign jtag_ready_o = 1'b0;
`endif

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    unique case (gnt)
      GNT_EX:   begin sel_addr = ex_waddr_i;   sel_data = ex_wdata_i;   end
      GNT_BUF:  begin sel_addr = buf_addr;     sel_data = buf_data;     end
      GNT_JTAG: begin sel_addr = jtag_waddr_i; sel_data = jtag_wdata_i; end
      default:  ;
    endcase
  end

  // register 0 is hardwired: the grant still completes but nothing is written
  assign wr = (gnt != GNT_NONE) && (sel_addr != '0) && !rst;

  assign we_o        = wr ? WriteEnable : 1'b0;
  assign waddr_o     = wr ? sel_addr : '0;
  assign wdata_o     = wr ? sel_data : '0;
  assign div_ready_o = ~buf_v & ~rst;
  assign pend_o      = buf_v & ~rst;
  assign stall_o     = stall & ~rst;
endmodule

// File: tb/tb_regs_wr_arb.sv
// Directed + randomized bench for regs_wr_arb against a behavioural model.
module tb_regs_wr_arb;
`ifdef REGS_WR_ARB_JTAG_EN
  localparam bit JTAG_EN = 1'b1;
`else
  localparam bit JTAG_EN = 1'b0;
`endif
  localparam int LIM = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ex_we = 0, div_valid = 0, jtag_valid = 0;
  logic [4:0]  ex_waddr = 0, div_waddr = 0, jtag_waddr = 0;
  logic [31:0] ex_wdata = 0, div_wdata = 0, jtag_wdata = 0;
  logic        div_ready, jtag_ready, we, stall, pend;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int checks = 0, failures = 0;

  // model state: buffer, preference (1 = jtag next), starvation count
  logic        m_bv, n_bv, m_rr, n_rr, g_jtag;
  logic [4:0]  m_ba, n_ba;
  logic [31:0] m_bd, n_bd;
  int          m_cnt, n_cnt;

  regs_wr_arb dut (
    .clk(clk), .rst(rst),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .div_valid_i(div_valid), .div_waddr_i(div_waddr), .div_wdata_i(div_wdata),
    .div_ready_o(div_ready),
    .jtag_valid_i(jtag_valid), .jtag_waddr_i(jtag_waddr), .jtag_wdata_i(jtag_wdata),
    .jtag_ready_o(jtag_ready),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .stall_o(stall), .pend_o(pend)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bv = 0; m_rr = 0; m_cnt = 0; m_ba = 0; m_bd = 0;
  endtask

  // Evaluate current cycle: compare DUT against model, compute next model state
  task automatic ev();
    int pick;  // 0 idle, 1 ex, 2 buffer, 3 jtag
    logic jt, e_we;
    logic [4:0] a;
    logic [31:0] d;
    #1;
    if (rst) begin
      chk("rst_we", 32'(we), 0);            chk("rst_waddr", 32'(waddr), 0);
      chk("rst_wdata", wdata, 0);           chk("rst_div_ready", 32'(div_ready), 0);
      chk("rst_jtag_ready", 32'(jtag_ready), 0);
      chk("rst_stall", 32'(stall), 0);      chk("rst_pend", 32'(pend), 0);
      g_jtag = 0;
      return;
    end
    jt = JTAG_EN && jtag_valid;
    pick = 0;
    if (ex_we)           pick = 1;
    else if (m_bv && jt) pick = m_rr ? 3 : 2;
    else if (m_bv)       pick = 2;
    else if (jt)         pick = 3;
    a = 0; d = 0;
    case (pick)
      1: begin a = ex_waddr;   d = ex_wdata;   end
      2: begin a = m_ba;       d = m_bd;       end
      3: begin a = jtag_waddr; d = jtag_wdata; end
      default: ;
    endcase
    e_we = (pick != 0) && (a != 0);
    if (!e_we) begin a = 0; d = 0; end
    chk("we", 32'(we), 32'(e_we));
    chk("waddr", 32'(waddr), 32'(a));
    chk("wdata", wdata, d);
    chk("div_ready", 32'(div_ready), 32'(!m_bv));
    chk("jtag_ready", 32'(jtag_ready), 32'(pick == 3));
    chk("stall", 32'(stall), 32'(m_bv && m_cnt == LIM));
    chk("pend", 32'(pend), 32'(m_bv));
    n_bv = m_bv; n_ba = m_ba; n_bd = m_bd; n_cnt = m_cnt; n_rr = m_rr;
    if (m_bv && (pick == 2 || (ex_we && ex_waddr == m_ba))) begin
      n_bv = 0; n_cnt = 0;
    end else if (m_bv && ex_we) begin
      n_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
    end else if (!m_bv && div_valid) begin
      n_bv = 1; n_ba = div_waddr; n_bd = div_wdata;
    end
    if (pick == 2) n_rr = 1;
    if (pick == 3) n_rr = 0;
    g_jtag = (pick == 3);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else begin m_bv = n_bv; m_ba = n_ba; m_bd = n_bd; m_cnt = n_cnt; m_rr = n_rr; end
    @(negedge clk);
  endtask

  task automatic idle_in();
    ex_we = 0; div_valid = 0; jtag_valid = 0;
  endtask

  initial begin
    model_reset();
    g_jtag = 0;
    @(negedge clk); ev(); tick();
    rst = 0;

    // div alone: written the cycle after acceptance
    div_valid = 1; div_waddr = 5; div_wdata = 32'h1234_5678;
    ev(); chk("div0_we", 32'(we), 0); tick();
    idle_in();
    ev(); chk("div1_we", 32'(we), 1); chk("div1_waddr", 32'(waddr), 5);
    chk("div1_wdata", wdata, 32'h1234_5678); tick();
    ev(); chk("div2_ready", 32'(div_ready), 1); tick();

    // starvation: buffer holds addr 7 while ex keeps writing addr 3
    div_valid = 1; div_waddr = 7; div_wdata = 32'h7777;
    ev(); tick();
    div_valid = 0; ex_we = 1; ex_waddr = 3;
    for (int k = 1; k <= 6; k++) begin
      ex_wdata = 32'(k);
      ev(); chk("starve_stall", 32'(stall), 32'(k >= 5)); chk("starve_addr", 32'(waddr), 3);
      tick();
    end
    ex_we = 0;
    ev(); chk("starve_drain_addr", 32'(waddr), 7); chk("starve_drain_we", 32'(we), 1); tick();
    ev(); chk("starve_released", 32'(stall), 0); chk("starve_pend", 32'(pend), 0); tick();

    // WAW kill: ex overwrites buffered addr 4
    ex_we = 1; ex_waddr = 1; ex_wdata = 32'h11;
    div_valid = 1; div_waddr = 4; div_wdata = 32'hAA;
    ev(); tick();
    div_valid = 0; ex_waddr = 4; ex_wdata = 32'hBB;
    ev(); chk("waw_wdata", wdata, 32'hBB); chk("waw_waddr", 32'(waddr), 4); tick();
    ex_we = 0;
    ev(); chk("waw_pend", 32'(pend), 0); chk("waw_no_write", 32'(we), 0); tick();

    // jtag to address 0: handshake only
    jtag_valid = 1; jtag_waddr = 0; jtag_wdata = 32'hFFFF_FFFF;
    ev(); chk("z_jtag_ready", 32'(jtag_ready), 32'(JTAG_EN)); chk("z_we", 32'(we), 0); tick();
    jtag_valid = 0;
    ev(); chk("z_jtag_ready_drop", 32'(jtag_ready), 0); tick();

    // reset mid-operation with a full buffer and pending jtag
    ex_we = 1; ex_waddr = 2; div_valid = 1; div_waddr = 9; div_wdata = 32'h99;
    ev(); tick();
    idle_in(); jtag_valid = 1; jtag_waddr = 12; jtag_wdata = 32'hC;
    #2 rst = 1;
    ev(); tick();
    rst = 0; jtag_valid = 0;
    ev(); chk("post_rst_pend", 32'(pend), 0); chk("post_rst_ready", 32'(div_ready), 1); tick();

    // round-robin from rr=0: buffer (addr 9) first, then jtag (addr 10)
    ex_we = 1; ex_waddr = 1; div_valid = 1; div_waddr = 9; div_wdata = 32'h9;
    ev(); tick();
    idle_in(); jtag_valid = 1; jtag_waddr = 10; jtag_wdata = 32'hA;
    ev(); chk("rr_first", 32'(waddr), 9); chk("rr_first_jr", 32'(jtag_ready), 0); tick();
    ev(); chk("rr_second", 32'(waddr), JTAG_EN ? 32'd10 : 32'd0);
    chk("rr_second_jr", 32'(jtag_ready), 32'(JTAG_EN)); tick();
    jtag_valid = 0;
    ev(); tick();

    // randomized traffic; jtag holds its request until granted
    for (int i = 0; i < 400; i++) begin
      ex_we = ($urandom_range(0, 9) < 4);
      ex_waddr = 5'($urandom_range(0, 7)); ex_wdata = $urandom;
      div_valid = $urandom_range(0, 1) == 1;
      div_waddr = 5'($urandom_range(0, 7)); div_wdata = $urandom;
      if (!jtag_valid && $urandom_range(0, 2) == 0) begin
        jtag_valid = 1; jtag_waddr = 5'($urandom_range(0, 7)); jtag_wdata = $urandom;
      end
      ev(); tick();
      if (g_jtag) jtag_valid = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
